gray_to_bcd_seq: RTL



---
 rtl/gray_to_bcd_seq_pkg.sv | 20 ++
 rtl/gray_to_bcd_seq_if.sv | 23 ++
 rtl/gray_to_bcd_seq_bcd_dabble_step.sv | 24 ++
 rtl/gray_to_bcd_seq.sv | 127 ++++++++++++
 4 files changed

// File: rtl/gray_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential Gray-to-packed-BCD converter.
package gray_to_bcd_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      G2B    = 2'd1,
      DABBLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int BCD_W   = 4;
   localparam int ADD3_TH = 5;
   localparam int ADD3    = 3;

   // Counter runs GW-1 down to 0, so it only needs to hold GW-1.
   function automatic int cnt_width(input int gw);
      return (gw > 2) ? $clog2(gw) : 1;
   endfunction

endpackage

// File: rtl/gray_to_bcd_seq_if.sv
// Valid/ready input and output channels of gray_to_bcd_seq.
interface gray_to_bcd_seq_if #(
   parameter int GW     = 8,
   parameter int DIGITS = 2
);
   logic                in_valid;
   logic                in_ready;
   logic [GW-1:0]       gray;
   logic                out_valid;
   logic                out_ready;
   logic [4*DIGITS-1:0] bcd;
   logic                error;

   modport master (
      output in_valid, gray, out_ready,
      input  in_ready, out_valid, bcd, error
   );

   modport slave (
      input  in_valid, gray, out_ready,
      output in_ready, out_valid, bcd, error
   );
endinterface

// File: rtl/gray_to_bcd_seq_bcd_dabble_step.sv
// One double-dabble step: add 3 to every digit >= 5, then shift left taking bit_in.
module bcd_dabble_step
   import gray_to_bcd_seq_pkg::*;
#(
   parameter int DIGITS = 2
) (
   input  logic [BCD_W*DIGITS-1:0] bcd_in,
   input  logic                    bit_in,
   output logic [BCD_W*DIGITS-1:0] bcd_out,
   output logic                    carry_out
);
   logic [BCD_W*DIGITS-1:0] adj;

   // NOTE: every variable written here gets a value before any condition, so no latch is inferred.
   always_comb begin
      adj = bcd_in;
      for (int d = 0; d < DIGITS; d++) begin
         if (adj[d*BCD_W +: BCD_W] >= BCD_W'(ADD3_TH))
            adj[d*BCD_W +: BCD_W] = adj[d*BCD_W +: BCD_W] + BCD_W'(ADD3);
      end
   end

   assign {carry_out, bcd_out} = {adj, bit_in};
endmodule

// File: rtl/gray_to_bcd_seq.sv
// Sequential Gray -> binary -> packed BCD converter with overflow flag.
// Define GRAY_BCD_FAST_G2B_EN to decode Gray combinationally at capture and skip G2B.
module gray_to_bcd_seq
   import gray_to_bcd_seq_pkg::*;
#(
   parameter int GW     = 8,
   parameter int DIGITS = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   gray_to_bcd_seq_if.slave       bus
);
   localparam int CW = cnt_width(GW);
   localparam int BW = BCD_W * DIGITS;
   localparam logic [CW-1:0] CNT_LOAD = CW'(GW - 1);

`ifdef GRAY_BCD_FAST_G2B_EN
   localparam state_t CAPTURE_NEXT = DABBLE;

   function automatic logic [GW-1:0] gray_to_bin(input logic [GW-1:0] g);
      logic [GW-1:0] b;
      b[GW-1] = g[GW-1];
      for (int i = GW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction
`else
   localparam state_t CAPTURE_NEXT = G2B;
   logic [GW-1:0] gray_q;
`endif

   state_t        state_q, state_d;
   logic [GW-1:0] bin_q;
   logic [CW-1:0] cnt_q;
   logic [BW-1:0] shreg_q;
   logic          ovf_q;
   logic [BW-1:0] bcd_q;
   logic          error_q;

   logic [BW-1:0] step_bcd;
   logic          step_carry;
   logic          cnt_zero;

   assign cnt_zero = (cnt_q == '0);

   bcd_dabble_step #(.DIGITS(DIGITS)) u_step (
      .bcd_in   (shreg_q),
      .bit_in   (bin_q[GW-1]),
      .bcd_out  (step_bcd),
      .carry_out(step_carry)
   );

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.in_valid)  state_d = CAPTURE_NEXT;
         G2B:     if (cnt_zero)      state_d = DABBLE;
         DABBLE:  if (cnt_zero)      state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   // NOTE: working registers are reset too; they are few, and it keeps every state observable after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_q   <= '0;
         cnt_q   <= '0;
         shreg_q <= '0;
         ovf_q   <= 1'b0;
         bcd_q   <= '0;
         error_q <= 1'b0;
`ifndef GRAY_BCD_FAST_G2B_EN
         gray_q  <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  cnt_q <= CNT_LOAD;
`ifdef GRAY_BCD_FAST_G2B_EN
                  bin_q   <= gray_to_bin(bus.gray);
                  shreg_q <= '0;
                  ovf_q   <= 1'b0;
`else
                  gray_q  <= bus.gray;
                  bin_q   <= '0;
`endif
               end
            end
`ifndef GRAY_BCD_FAST_G2B_EN
            G2B: begin
               // bin_q[0] is the previously decoded (higher) bit; it is 0 on the first step.
               bin_q <= {bin_q[GW-2:0], bin_q[0] ^ gray_q[cnt_q]};
               cnt_q <= cnt_q - CW'(1);
               if (cnt_zero) begin
                  cnt_q   <= CNT_LOAD;
                  shreg_q <= '0;
                  ovf_q   <= 1'b0;
               end
            end
`endif
            DABBLE: begin
               shreg_q <= step_bcd;
               bin_q   <= {bin_q[GW-2:0], 1'b0};
               ovf_q   <= ovf_q | step_carry;
               cnt_q   <= cnt_q - CW'(1);
               if (cnt_zero) begin
                  bcd_q   <= step_bcd;
                  error_q <= ovf_q | step_carry;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.bcd       = bcd_q;
   assign bus.error     = error_q;
endmodule
